// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: alignment check, byte-enable/lane steering,
// load extraction. Optional ACCESS timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lsu_ctrl: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic        we_q;
  logic [2:0]  typ_q;
  logic [1:0]  alo_q;
  logic        legal, misal, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Request decode, evaluated from the live inputs in IDLE
  always_comb begin
    legal   = 1'b0;
    misal   = 1'b0;
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_type)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
    case (req_type[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misal   = req_addr[0];
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: misal = |req_addr[1:0];
    endcase
  end

  // Little-endian lane select and extension of the returned word
  always_comb begin
    byte_sel = mem_rdata[8*alo_q +: 8];
    half_sel = mem_rdata[16*alo_q[1] +: 16];
    case (typ_q)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'd0, byte_sel};
      3'b101:  ld_data = {16'd0, half_sel};
      default: ld_data = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      to_cnt <= 8'd0;
    else if (state != ACCESS)     to_cnt <= 8'd0;
    else if (!mem_ack)            to_cnt <= to_cnt + 8'd1;
  end

  // Fires on the last permitted ACCESS cycle; a same-cycle ack takes priority
  assign timeout = (state == ACCESS) && !mem_ack &&
                   (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = (state == IDLE);
    mem_req    = (state == ACCESS);
    resp_valid = (state == RESP);
    case (state)
      IDLE:    if (req_valid) state_nxt = (legal && !misal) ? ACCESS : RESP;
      ACCESS:  if (mem_ack || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
      we_q      <= 1'b0;
      typ_q     <= 3'd0;
      alo_q     <= 2'd0;
    end else begin
      if (state == IDLE && req_valid) begin
        if (legal && !misal) begin
          mem_we    <= req_we;
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_wdata <= wdata_d;
          mem_be    <= be_d;
          we_q      <= req_we;
          typ_q     <= req_type;
          alo_q     <= req_addr[1:0];
        end else begin
          resp_err  <= 1'b1;
          resp_data <= 32'd0;
        end
      end
      if (state == ACCESS && mem_ack) begin
        resp_err  <= 1'b0;
        resp_data <= we_q ? 32'd0 : ld_data;
      end else if (timeout) begin
        resp_err  <= 1'b1;
        resp_data <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl; the timeout case runs only when LSU_TIMEOUT_EN is defined.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
`else
  lsu_ctrl dut (
`endif
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns just after the accept edge
  task automatic issue(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    step();

    // LB 0x103, single-cycle memory
    issue(1'b0, 3'b000, 32'h103, 32'd0);
    chk("lb_mem_req", mem_req, 1);
    chk("lb_mem_addr", mem_addr, 32'h100);
    chk("lb_mem_be", mem_be, 4'b1000);
    chk("lb_mem_we", mem_we, 0);
    chk("lb_ready_busy", req_ready, 0);
    chk("lb_no_early_resp", resp_valid, 0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    step();
    mem_ack = 1'b0;
    chk("lb_resp_valid", resp_valid, 1);
    chk("lb_resp_data", resp_data, 32'hFFFF_FF80);
    chk("lb_resp_err", resp_err, 0);
    chk("lb_req_dropped", mem_req, 0);
    step();
    chk("lb_resp_once", resp_valid, 0);
    chk("lb_ready_back", req_ready, 1);
    chk("lb_data_held", resp_data, 32'hFFFF_FF80);

    // Stray ack while idle must not produce a response
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("idle_ack_ignored", resp_valid, 0);

    // SB 0x11
    issue(1'b1, 3'b000, 32'h11, 32'h0000_00A5);
    chk("sb_mem_we", mem_we, 1);
    chk("sb_mem_be", mem_be, 4'b0010);
    chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_mem_addr", mem_addr, 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    chk("sb_resp_valid", resp_valid, 1);
    chk("sb_resp_data", resp_data, 0);
    chk("sb_resp_err", resp_err, 0);
    step();

    // LHU 0x202, ack after three wait cycles
    issue(1'b0, 3'b101, 32'h202, 32'd0);
    chk("lhu_mem_be", mem_be, 4'b1100);
    mem_rdata = 32'hBEEF_0001;
    for (int i = 0; i < 3; i++) begin
      chk("lhu_req_held", mem_req, 1);
      chk("lhu_no_resp", resp_valid, 0);
      step();
    end
    chk("lhu_req_4th", mem_req, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lhu_resp_valid", resp_valid, 1);
    chk("lhu_resp_data", resp_data, 32'h0000_BEEF);
    step();

    // LW misaligned: error response one cycle after accept, no memory request
    issue(1'b0, 3'b010, 32'h06, 32'd0);
    chk("lw_mis_no_req", mem_req, 0);
    chk("lw_mis_resp_valid", resp_valid, 1);
    chk("lw_mis_err", resp_err, 1);
    chk("lw_mis_data", resp_data, 0);
    step();
    chk("lw_mis_idle", req_ready, 1);

    // Store with unsigned type is illegal
    issue(1'b1, 3'b101, 32'h20, 32'h1234_5678);
    chk("sh_ill_no_req", mem_req, 0);
    chk("sh_ill_resp_valid", resp_valid, 1);
    chk("sh_ill_err", resp_err, 1);
    step();

    // LH 0x00 sign-extends lower halfword
    issue(1'b0, 3'b001, 32'h00, 32'd0);
    chk("lh_mem_be", mem_be, 4'b0011);
    mem_ack = 1'b1; mem_rdata = 32'h1111_8001;
    step();
    mem_ack = 1'b0;
    chk("lh_resp_data", resp_data, 32'hFFFF_8001);
    chk("lh_resp_err", resp_err, 0);
    step();

    // Reset mid-ACCESS drops mem_req without a clock edge
    issue(1'b0, 3'b010, 32'h40, 32'd0);
    chk("rst_mid_req_before", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req_async", mem_req, 0);
    chk("rst_mid_be", mem_be, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    rst = 1'b0;
    step();
    chk("rst_mid_no_resp", resp_valid, 0);
    chk("rst_mid_ready", req_ready, 1);
    issue(1'b0, 3'b010, 32'h44, 32'd0);
    chk("post_rst_addr", mem_addr, 32'h44);
    chk("post_rst_be", mem_be, 4'b1111);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    chk("post_rst_resp_valid", resp_valid, 1);
    chk("post_rst_data", resp_data, 32'h1234_5678);
    step();

`ifdef LSU_TIMEOUT_EN
    // No ack: four request cycles, then an error response
    issue(1'b0, 3'b010, 32'h80, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", mem_req, 1);
      step();
    end
    chk("to_req_dropped", mem_req, 0);
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_data", resp_data, 0);
    step();
    // Ack on the fourth cycle beats the timeout
    issue(1'b0, 3'b010, 32'h84, 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("to_ack4_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    chk("to_ack4_valid", resp_valid, 1);
    chk("to_ack4_err", resp_err, 0);
    chk("to_ack4_data", resp_data, 32'hCAFE_F00D);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
